// File: rtl/mini_calc_pkg.sv
// Shared opcode constants and default widths for the mini_calc calculator.
package mini_calc_pkg;

  localparam int unsigned INPUT_BIT_WIDTH = 8;
  localparam int unsigned INSTR_BIT_WIDTH = 4;

  localparam logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP     = 4'b1111;
  localparam logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_ADD_SUB = 4'b0111;
  localparam logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_MIN_MAX = 4'b1011;
  localparam logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_MUL     = 4'b1101;
  localparam logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_DIV     = 4'b1110;

endpackage

// File: rtl/mini_calc_divider.sv
// W-cycle restoring divider with start/abort control; divide by zero yields all ones
// and the dividend as remainder.
module mini_calc_divider #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         held,
  output logic [W-1:0] cap_a,
  output logic [W-1:0] cap_b,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

  logic [W-1:0]    a_q, b_q, rem_q, quo_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q, held_q;

  logic [W:0]   shifted;
  logic [W-1:0] diff, rem_nxt, quo_nxt;
  logic         ge;

  // One restoring step: bring in the next dividend bit and try to subtract the divisor.
  always_comb begin
    shifted = {rem_q, quo_q[W-1]};
    ge      = shifted >= {1'b0, b_q};
    diff    = shifted[W-1:0] - b_q;
    rem_nxt = ge ? diff : shifted[W-1:0];
    quo_nxt = {quo_q[W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      held_q <= 1'b0;
    end else if (start) begin
      a_q    <= a;
      b_q    <= b;
      rem_q  <= '0;
      quo_q  <= a;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      held_q <= 1'b0;
    end else if (abort) begin
      busy_q <= 1'b0;
      held_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastCnt) begin
        busy_q <= 1'b0;
        held_q <= 1'b1;
      end
    end
  end

  assign busy      = busy_q;
  assign held      = held_q;
  assign cap_a     = a_q;
  assign cap_b     = b_q;
  assign done      = busy_q && !start && !abort && (cnt_q == LastCnt);
  assign quotient  = (b_q == '0) ? '1 : quo_nxt;
  assign remainder = (b_q == '0) ? a_q : rem_nxt;

endmodule

// File: rtl/mini_calc.sv
// Registered two-operand calculator. Define MINI_CALC_DIV_EN to build the sequential
// divider; otherwise DIV decodes as NOP and Busy is tied low.
module mini_calc
  import mini_calc_pkg::*;
#(
  parameter int unsigned W  = INPUT_BIT_WIDTH,
  parameter int unsigned IW = INSTR_BIT_WIDTH
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic [IW-1:0] Instruction,
  input  logic [W-1:0]  InputA,
  input  logic [W-1:0]  InputB,
  output logic [W-1:0]  OutputA,
  output logic [W-1:0]  OutputB,
  output logic          Busy
);

  logic [W-1:0]   out_a_q, out_b_q;
  logic [W-1:0]   res_a, res_b;
  logic [2*W-1:0] prod;

  assign prod = {{W{1'b0}}, InputA} * {{W{1'b0}}, InputB};

  always_comb begin
    res_a = '0;
    res_b = '0;
    unique case (Instruction)
      CODE_INSTR_ADD_SUB: begin
        res_a = InputA + InputB;
        res_b = InputA - InputB;
      end
      CODE_INSTR_MIN_MAX: begin
        res_a = (InputA >= InputB) ? InputA : InputB;
        res_b = (InputA >= InputB) ? InputB : InputA;
      end
      CODE_INSTR_MUL: begin
        res_a = prod[W-1:0];
        res_b = prod[2*W-1:W];
      end
      default: begin
        res_a = '0;
        res_b = '0;
      end
    endcase
  end

`ifdef MINI_CALC_DIV_EN
  logic         div_sel, div_start, div_busy, div_done, div_held;
  logic [W-1:0] cap_a, cap_b, quotient, remainder;

  assign div_sel = (Instruction == CODE_INSTR_DIV);
  // Restart on new operands, or when no result is held for the current operands.
  assign div_start = div_sel &&
                     (({InputA, InputB} != {cap_a, cap_b}) || (!div_busy && !div_held));

  mini_calc_divider #(
    .W (W)
  ) u_divider (
    .clk       (Clk),
    .rst_n     (nReset),
    .start     (div_start),
    .abort     (!div_sel),
    .a         (InputA),
    .b         (InputB),
    .busy      (div_busy),
    .done      (div_done),
    .held      (div_held),
    .cap_a     (cap_a),
    .cap_b     (cap_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else if (div_sel) begin
      if (div_done) begin
        out_a_q <= quotient;
        out_b_q <= remainder;
      end
    end else begin
      out_a_q <= res_a;
      out_b_q <= res_b;
    end
  end

  assign Busy = div_busy;
`else
  always_ff @(posedge Clk) begin
    if (!nReset) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= res_a;
      out_b_q <= res_b;
    end
  end

  assign Busy = 1'b0;
`endif

  assign OutputA = out_a_q;
  assign OutputB = out_b_q;

endmodule

// File: tb/tb_mini_calc.sv
// Directed, table-driven bench for mini_calc; divider sequences run when MINI_CALC_DIV_EN is set.
module tb_mini_calc;

  localparam int unsigned W = 8;

  localparam logic [3:0] OpNop = 4'b1111;
  localparam logic [3:0] OpAdd = 4'b0111;
  localparam logic [3:0] OpMm  = 4'b1011;
  localparam logic [3:0] OpMul = 4'b1101;
  localparam logic [3:0] OpDiv = 4'b1110;
  localparam logic [3:0] OpBad = 4'b0000;

  logic         Clk = 1'b0;
  logic         nReset;
  logic [3:0]   Instruction;
  logic [W-1:0] InputA, InputB;
  logic [W-1:0] OutputA, OutputB;
  logic         Busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prev_a, prev_b;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
  } vec_t;

  vec_t vecs[$];

  mini_calc u_dut (
    .Clk         (Clk),
    .nReset      (nReset),
    .Instruction (Instruction),
    .InputA      (InputA),
    .InputB      (InputB),
    .OutputA     (OutputA),
    .OutputB     (OutputB),
    .Busy        (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Instruction = op;
    InputA      = a;
    InputB      = b;
  endtask

  // Runs a divide from its start edge; outputs must hold prev_a/prev_b while busy.
  task automatic div_run(input string name, input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input int busy_edges);
    for (int i = 0; i < busy_edges; i++) begin
      step();
      check({name, " busy"}, {7'b0, Busy}, 8'd1);
      check({name, " holdA"}, OutputA, prev_a);
      check({name, " holdB"}, OutputB, prev_b);
    end
    step();
    check({name, " doneBusy"}, {7'b0, Busy}, 8'd0);
    check({name, " quot"}, OutputA, ea);
    check({name, " rem"}, OutputB, eb);
    prev_a = ea;
    prev_b = eb;
  endtask

  initial begin
    vecs.push_back('{OpAdd, 8'd6,   8'd3,   8'd9,   8'd3});
    vecs.push_back('{OpAdd, 8'd8,   8'd5,   8'd13,  8'd3});
    vecs.push_back('{OpAdd, 8'd3,   8'd5,   8'd8,   8'd254});
    vecs.push_back('{OpAdd, 8'd200, 8'd100, 8'd44,  8'd100});
    vecs.push_back('{OpMm,  8'd6,   8'd3,   8'd6,   8'd3});
    vecs.push_back('{OpMm,  8'd3,   8'd11,  8'd11,  8'd3});
    vecs.push_back('{OpMm,  8'd0,   8'd2,   8'd2,   8'd0});
    vecs.push_back('{OpMm,  8'd5,   8'd8,   8'd8,   8'd5});
    vecs.push_back('{OpMm,  8'd7,   8'd7,   8'd7,   8'd7});
    vecs.push_back('{OpMul, 8'd6,   8'd3,   8'd18,  8'd0});
    vecs.push_back('{OpMul, 8'd20,  8'd20,  8'd144, 8'd1});
    vecs.push_back('{OpMul, 8'd255, 8'd255, 8'd1,   8'd254});
    vecs.push_back('{OpNop, 8'd6,   8'd3,   8'd0,   8'd0});
    vecs.push_back('{OpBad, 8'd6,   8'd3,   8'd0,   8'd0});
    vecs.push_back('{OpMul, 8'd12,  8'd11,  8'd132, 8'd0});
`ifndef MINI_CALC_DIV_EN
    vecs.push_back('{OpDiv, 8'd15,  8'd2,   8'd0,   8'd0});
`endif

    nReset = 1'b0;
    drive(OpAdd, 8'd6, 8'd3);
    step();
    step();
    check("reset OutputA", OutputA, 8'd0);
    check("reset OutputB", OutputB, 8'd0);
    check("reset Busy", {7'b0, Busy}, 8'd0);
    nReset = 1'b1;
    step();
    check("post-reset OutputA", OutputA, 8'd9);
    check("post-reset OutputB", OutputB, 8'd3);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      check($sformatf("vec%0d A", i), OutputA, vecs[i].ea);
      check($sformatf("vec%0d B", i), OutputB, vecs[i].eb);
      check($sformatf("vec%0d Busy", i), {7'b0, Busy}, 8'd0);
      prev_a = vecs[i].ea;
      prev_b = vecs[i].eb;
    end

`ifdef MINI_CALC_DIV_EN
    drive(OpDiv, 8'd15, 8'd2);
    div_run("div15_2", 8'd7, 8'd1, W);
    step();
    check("div hold A", OutputA, 8'd7);
    check("div hold B", OutputB, 8'd1);
    check("div hold Busy", {7'b0, Busy}, 8'd0);

    drive(OpDiv, 8'd200, 8'd7);
    div_run("div200_7", 8'd28, 8'd4, W);

    drive(OpDiv, 8'd9, 8'd0);
    div_run("div9_0", 8'd255, 8'd9, W);

    // Abort by operand change after three busy cycles.
    drive(OpDiv, 8'd100, 8'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort pre busy", {7'b0, Busy}, 8'd1);
    end
    drive(OpDiv, 8'd50, 8'd5);
    div_run("div50_5", 8'd10, 8'd0, W);

    // Abort by switching to MIN_MAX mid-divide.
    drive(OpDiv, 8'd200, 8'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mm pre busy", {7'b0, Busy}, 8'd1);
    end
    drive(OpMm, 8'd6, 8'd3);
    step();
    check("mm abort Busy", {7'b0, Busy}, 8'd0);
    check("mm abort A", OutputA, 8'd6);
    check("mm abort B", OutputB, 8'd3);

    // Reset mid-division.
    drive(OpDiv, 8'd77, 8'd4);
    step();
    step();
    nReset = 1'b0;
    step();
    check("rst mid Busy", {7'b0, Busy}, 8'd0);
    check("rst mid A", OutputA, 8'd0);
    nReset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
